// File: rtl/debounce_multi_pkg.sv
// rtl/debounce_multi_pkg.sv - shared elaboration helpers for the button conditioner
package debounce_multi_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int db_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, stable-count filter, edge pulses,
// long-press and auto-repeat
module debounce_channel
  import debounce_multi_pkg::*;
#(
  parameter int STABLE_SAMPLES = 8,
  parameter int HOLD_SAMPLES   = 1000,
  parameter int REPEAT_SAMPLES = 200,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic tick,
  input  logic btn_raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic repeat_press,
  output logic held
);

  localparam int CW  = clog2(max2(STABLE_SAMPLES + 1, 2));
  localparam int HW  = clog2(max2(max2(HOLD_SAMPLES, REPEAT_SAMPLES) + 1, 2));
  localparam int HW1 = HW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
  localparam logic [HW:0]   HOLD_V   = HW1'(HOLD_SAMPLES);
  localparam logic [HW:0]   REP_V    = HW1'(REPEAT_SAMPLES);

  if (STABLE_SAMPLES < 1) begin : g_bad_stable
    $error("debounce_channel: STABLE_SAMPLES must be >= 1");
  end
  if (HOLD_SAMPLES < 1) begin : g_bad_hold
    $error("debounce_channel: HOLD_SAMPLES must be >= 1");
  end

  logic          sync1;
  logic          sync2;
  logic          pressed;
  logic          flip;
  logic          rel_tick;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hc;
  logic [HW:0]   hc_next;

  assign pressed  = sync2 ^ ACTIVE_LOW;
  assign flip     = tick && (pressed != db) && (cnt == CNT_LAST);
  assign rel_tick = flip && db;
  assign hc_next  = {1'b0, hc} + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1        <= ACTIVE_LOW;
      sync2        <= ACTIVE_LOW;
      cnt          <= '0;
      db           <= 1'b0;
      rise         <= 1'b0;
      fall         <= 1'b0;
      hc           <= '0;
      held         <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
    end else begin
      rise         <= 1'b0;
      fall         <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;

      if (enable) begin
        sync1 <= btn_raw;
        sync2 <= sync1;
      end

      // Any agreeing sample restarts the count, so bounce never accumulates.
      if (tick) begin
        if (pressed == db) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          db   <= pressed;
          cnt  <= '0;
          rise <= pressed;
          fall <= !pressed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // The tick that sets db sees db==0 here, so it never counts toward the hold.
      if (!db || rel_tick) begin
        hc   <= '0;
        held <= 1'b0;
      end else if (tick) begin
        if (!held) begin
          if (hc_next == HOLD_V) begin
            long_press <= 1'b1;
            held       <= 1'b1;
            hc         <= '0;
          end else begin
            hc <= hc_next[HW-1:0];
          end
        end else if (REPEAT_SAMPLES > 0) begin
          if (hc_next == REP_V) begin
            repeat_press <= 1'b1;
            hc           <= '0;
          end else begin
            hc <= hc_next[HW-1:0];
          end
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - shared sample-tick divider feeding CHANNELS independent
// button conditioners
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int CLK_FREQ_HZ    = 12000000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int STABLE_SAMPLES = 8,
  parameter int HOLD_SAMPLES   = 1000,
  parameter int REPEAT_SAMPLES = 200,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_db,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_long,
  output logic [CHANNELS-1:0] btn_repeat,
  output logic [CHANNELS-1:0] btn_held,
  output logic                sample_tick
);

  localparam int DIV = db_div(CLK_FREQ_HZ, SAMPLE_HZ);
  localparam int DW  = max2(clog2(DIV), 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("debounce_multi: CLK_FREQ_HZ/SAMPLE_HZ must be >= 2");
  end

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign sample_tick = enable && (div_cnt == DIV_LAST);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .HOLD_SAMPLES  (HOLD_SAMPLES),
      .REPEAT_SAMPLES(REPEAT_SAMPLES),
      .ACTIVE_LOW    (ACTIVE_LOW != 0)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .tick        (sample_tick),
      .btn_raw     (btn_in[i]),
      .db          (btn_db[i]),
      .rise        (btn_rise[i]),
      .fall        (btn_fall[i]),
      .long_press  (btn_long[i]),
      .repeat_press(btn_repeat[i]),
      .held        (btn_held[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - directed bench for debounce_multi (DIV=10, 4 stable,
// 20 hold, 5 repeat); cycle numbers count posedges since the last reset release
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] btn_in;
  logic [3:0] btn_db, btn_rise, btn_fall, btn_long, btn_repeat, btn_held;
  logic       sample_tick;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int tick_n = 0;
  int t0;
  int rise_n[4], fall_n[4], long_n[4];
  int rep0_q[$];
  int rep0_exp[4] = '{290, 340, 390, 440};
  bit tog_on  = 1'b0;
  bit db1_seen = 1'b0;

  debounce_multi #(
    .CHANNELS(4), .CLK_FREQ_HZ(1000), .SAMPLE_HZ(100), .STABLE_SAMPLES(4),
    .HOLD_SAMPLES(20), .REPEAT_SAMPLES(5), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .btn_in(btn_in),
    .btn_db(btn_db), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .btn_long(btn_long), .btn_repeat(btn_repeat), .btn_held(btn_held),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin
      rise_n[c] = 0;
      fall_n[c] = 0;
      long_n[c] = 0;
    end
    rep0_q.delete();
  endtask

  // Advance n clocks, sampling at each negedge; ch1 bounces every 25 clk while tog_on.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      tick_n += int'(sample_tick);
      for (int c = 0; c < 4; c++) begin
        rise_n[c] += int'(btn_rise[c]);
        fall_n[c] += int'(btn_fall[c]);
        long_n[c] += int'(btn_long[c]);
      end
      if (btn_repeat[0]) rep0_q.push_back(cyc);
      if (btn_db[1]) db1_seen = 1'b1;
      if (tog_on && cyc <= 300 && cyc % 25 == 0) btn_in[1] = ~btn_in[1];
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b1;
    btn_in = 4'b1111;
    clear_counts();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_db", 32'(btn_db), 32'h0);
    chk("rst_pulses", 32'({btn_rise, btn_fall, btn_long, btn_repeat}), 32'h0);
    chk("rst_held", 32'(btn_held), 32'h0);
    chk("rst_tick", 32'(sample_tick), 32'h0);

    // ch0 pressed cleanly, ch1 bouncing for 300 clk
    btn_in = 4'b1110;
    tog_on = 1'b1;
    rst_n  = 1'b1;
    cyc    = 0;
    step(8);
    chk("tick_c8", 32'(sample_tick), 32'h0);
    step(1);
    chk("tick_c9", 32'(sample_tick), 32'h1);
    step(30);
    chk("db0_c39", 32'(btn_db), 32'h0);
    step(1);
    chk("db0_c40", 32'(btn_db), 32'h1);
    chk("rise0_c40", 32'(btn_rise), 32'h1);
    step(1);
    chk("rise0_c41", 32'(btn_rise), 32'h0);
    chk("rise0_n", 32'(rise_n[0]), 32'd1);
    step(198);
    chk("held0_c239", 32'(btn_held), 32'h0);
    chk("long0_c239", 32'(btn_long), 32'h0);
    step(1);
    chk("long0_c240", 32'(btn_long), 32'h1);
    chk("held0_c240", 32'(btn_held), 32'h1);
    step(200);
    chk("rep0_c440", 32'(btn_repeat), 32'h1);
    btn_in[0] = 1'b1;
    step(39);
    chk("held0_c479", 32'(btn_held), 32'h1);
    step(1);
    chk("fall0_c480", 32'(btn_fall), 32'h1);
    chk("held0_c480", 32'(btn_held), 32'h0);
    chk("db0_c480", 32'(btn_db), 32'h0);
    step(40);
    chk("rep0_n", 32'(rep0_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rep0_q.size(); i++)
      chk($sformatf("rep0_cyc%0d", i), 32'(rep0_q[i]), 32'(rep0_exp[i]));
    chk("long0_n", 32'(long_n[0]), 32'd1);
    chk("fall0_n", 32'(fall_n[0]), 32'd1);
    chk("ch1_db_seen", 32'(db1_seen), 32'h0);
    chk("ch1_edges", 32'(rise_n[1] + fall_n[1]), 32'd0);
    chk("ch23_rise", 32'(rise_n[2] + rise_n[3]), 32'd0);

    // ch3 pressed, then ch2 press and ch3 release land on the same tick
    tog_on = 1'b0;
    btn_in[3] = 1'b0;
    step(40);
    chk("rise3_c560", 32'(btn_rise), 32'h8);
    step(40);
    btn_in[2] = 1'b0;
    btn_in[3] = 1'b1;
    step(39);
    chk("db_c639", 32'(btn_db), 32'h8);
    step(1);
    chk("rise2_c640", 32'(btn_rise), 32'h4);
    chk("fall3_c640", 32'(btn_fall), 32'h8);
    chk("db_c640", 32'(btn_db), 32'h4);

    // asynchronous reset mid-hold, between clock edges
    step(60);
    chk("db_pre_rst", 32'(btn_db), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_db", 32'(btn_db), 32'h0);
    chk("async_pulses", 32'({btn_rise, btn_fall, btn_long, btn_repeat}), 32'h0);
    chk("async_held", 32'(btn_held), 32'h0);
    @(negedge clk);
    @(negedge clk);
    clear_counts();
    rst_n = 1'b1;
    cyc   = 0;
    step(39);
    chk("db2_c39", 32'(btn_db), 32'h0);
    step(1);
    chk("rise2_c40", 32'(btn_rise), 32'h4);
    step(199);
    chk("held2_c239", 32'(btn_held), 32'h0);
    step(1);
    chk("long2_c240", 32'(btn_long), 32'h4);
    chk("held2_c240", 32'(btn_held), 32'h4);

    // freeze ch1 debounce at cnt=2 and ch2 repeat at hc=2
    btn_in[1] = 1'b0;
    step(20);
    chk("db1_c260", 32'(btn_db), 32'h4);
    enable = 1'b0;
    t0 = tick_n;
    step(500);
    chk("frozen_ticks", 32'(tick_n - t0), 32'd0);
    chk("frozen_db", 32'(btn_db), 32'h4);
    chk("frozen_tick", 32'(sample_tick), 32'h0);
    enable = 1'b1;
    step(19);
    chk("db1_c779", 32'(btn_db), 32'h4);
    step(1);
    chk("db1_c780", 32'(btn_db), 32'h6);
    chk("rise1_c780", 32'(btn_rise), 32'h2);
    chk("rep_c780", 32'(btn_repeat), 32'h0);
    step(10);
    chk("rep2_c790", 32'(btn_repeat), 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
